// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - frame serialiser/deserialiser driving an external SISO flop chain.
// Optional even-parity bit appended to each frame when SHIFT_PARITY_EN is defined.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ready,
    output logic             si,
    input  logic             so,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             parity_err
);

`ifdef SHIFT_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N + DEPTH + 1);

    localparam logic [CW-1:0] C_SHIFT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_FLUSH_LAST = CW'(N + DEPTH - 1);
    localparam logic [CW-1:0] C_RX_FIRST   = CW'(DEPTH);
    localparam logic [CW-1:0] C_RX_LAST    = CW'(DEPTH + N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    c_q, c_d;
    logic [N-1:0]     tx_sr_q, tx_sr_d;
    logic [N-1:0]     rx_sr_q, rx_sr_d;
    logic             si_q, si_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [N-1:0]     frame;
    logic             rx_load;

`ifdef SHIFT_PARITY_EN
    assign frame = {^tx_data, tx_data};
`else
    assign frame = tx_data;
`endif

    assign ready    = (state_q == S_IDLE);
    assign busy     = (state_q == S_SHIFT) || (state_q == S_FLUSH);
    assign si       = si_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_load  = (state_q == S_FLUSH) && (c_q == C_FLUSH_LAST);

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        si_d       = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        // Received bits enter at the MSB so bit 0 ends up holding the first one sent.
        if (busy && (c_q >= C_RX_FIRST) && (c_q <= C_RX_LAST)) begin
            rx_sr_d = {so, rx_sr_q[N-1:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    c_d     = '0;
                    tx_sr_d = frame >> 1;
                    si_d    = frame[0];
                end
            end
            S_SHIFT: begin
                c_d     = c_q + 1'b1;
                tx_sr_d = tx_sr_q >> 1;
                si_d    = tx_sr_q[0];
                if (c_q == C_SHIFT_LAST) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                c_d = c_q + 1'b1;
                if (rx_load) begin
                    state_d    = S_DONE;
                    rx_data_d  = rx_sr_d[WIDTH-1:0];
                    rx_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            c_q        <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            si_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            si_q       <= si_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef SHIFT_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (rx_load) begin
            parity_err_q <= ^rx_sr_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard bench for shift_seq_ctrl with looped-back flop chains.
module tb_shift_seq_ctrl;

`ifdef SHIFT_PARITY_EN
    localparam int  PX  = 1;
    localparam logic PAR = 1'b1;
`else
    localparam int  PX  = 0;
    localparam logic PAR = 1'b0;
`endif
    localparam int N1 = 8 + PX;
    localparam int N2 = 2 + PX;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start2;
    logic [7:0] tx_data;
    logic [1:0] tx2;
    logic       ready, si, so, busy, rx_valid, parity_err;
    logic [7:0] rx_data;
    logic       ready2, si2, so2, busy2, rx_valid2, parity_err2;
    logic [1:0] rx_data2;
    logic [3:0] chain;
    logic       chain2;
    logic       flip;

    int   checks = 0;
    int   errors = 0;
    int   rxv_count = 0;
    exp_t sb[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .ready(ready), .si(si), .so(so), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err)
    );

    shift_seq_ctrl #(.WIDTH(2), .DEPTH(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .tx_data(tx2),
        .ready(ready2), .si(si2), .so(so2), .busy(busy2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .parity_err(parity_err2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain  <= '0;
            chain2 <= 1'b0;
        end else begin
            chain  <= {chain[2:0], si};
            chain2 <= si2;
        end
    end
    assign so  = chain[3] ^ flip;
    assign so2 = chain2;

    // Scoreboard: every rx_valid pulse pops the frame expected next.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            rxv_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rx_valid rx_data=%h expected no pulse", rx_data);
            end else begin
                e = sb.pop_front();
                if (rx_data !== e.d || parity_err !== e.p) begin
                    errors++;
                    $display("FAIL rx_frame got data=%h perr=%b expected data=%h perr=%b",
                             rx_data, parity_err, e.d, e.p);
                end
            end
        end
        if (rx_valid2 === 1'b1) begin
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rx_valid2 rx_data2=%b expected no pulse", rx_data2);
            end else begin
                e = sb2.pop_front();
                if ({6'd0, rx_data2} !== e.d || parity_err2 !== e.p) begin
                    errors++;
                    $display("FAIL rx_frame2 got data=%b perr=%b expected data=%b perr=%b",
                             rx_data2, parity_err2, e.d[1:0], e.p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout ready=%b expected 1", name, ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start2 = 1'b0; tx_data = '0; tx2 = '0; flip = 1'b0;
        step();
        step();
        checks++;
        if ({ready, busy, si, rx_valid, parity_err, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b si=%b v=%b pe=%b d=%h expected 1 0 0 0 0 00",
                     ready, busy, si, rx_valid, parity_err, rx_data);
        end
        reset = 1'b0;
        step();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got rdy=%b busy=%b rdy2=%b expected 1 0 1", ready, busy, ready2);
        end
    endtask

    task automatic test_single();
        logic [7:0] bits = 8'hA5;
        int n;
        start = 1'b1; tx_data = 8'hA5;
        step();
        sb.push_back('{8'hA5, 1'b0});
        start = 1'b0; tx_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (si !== bits[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL si_bit%0d got si=%b busy=%b expected si=%b busy=1", k, si, busy, bits[k]);
            end
            step();
        end
        n = 9;
        while (rx_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != N1 + 4 + 1) begin
            errors++;
            $display("FAIL rx_valid_latency got %0d expected %0d", n, N1 + 5);
        end
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_outputs got rdy=%b busy=%b expected 0 0", ready, busy);
        end
        step();
        checks++;
        if (ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL after_done got rdy=%b v=%b d=%h expected 1 0 a5", ready, rx_valid, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int n = 1;
        start = 1'b1; tx_data = 8'h3C;
        step();
        sb.push_back('{8'h3C, 1'b0});
        tx_data = 8'hFF;
        while (ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != N1 + 4 + 2) begin
            errors++;
            $display("FAIL b2b_period got %0d expected %0d", n, N1 + 6);
        end
        sb.push_back('{8'hFF, 1'b0});
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept got busy=%b expected 1", busy);
        end
        wait_ready("b2b");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_ignore_start();
        int c0 = rxv_count;
        int busy_seen = 0;
        start = 1'b1; tx_data = 8'h5A;
        step();
        sb.push_back('{8'h5A, 1'b0});
        start = 1'b0;
        step(); step(); step();
        start = 1'b1; tx_data = 8'hFF;
        step();
        start = 1'b0;
        wait_ready("ignore");
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) busy_seen++;
            step();
        end
        checks++;
        if (busy_seen != 0 || rxv_count - c0 != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL ignore_start got busy_cycles=%0d pulses=%0d expected 0 1", busy_seen, rxv_count - c0);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        start = 1'b1; tx_data = 8'hD3;
        step();
        sb.push_back('{8'hD3, 1'b0});
        start = 1'b0;
        step(); step(); step(); step();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({ready, busy, si, rx_valid, rx_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset got rdy=%b busy=%b si=%b v=%b d=%h expected 1 0 0 0 00",
                     ready, busy, si, rx_valid, rx_data);
        end
        sb.delete();
        step();
        step();
        reset = 1'b0;
        c0 = rxv_count;
        start = 1'b1; tx_data = 8'h01;
        step();
        sb.push_back('{8'h01, 1'b0});
        start = 1'b0;
        wait_ready("after_reset");
        checks++;
        if (rxv_count - c0 != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_recovery got pulses=%0d pending=%0d expected 1 0", rxv_count - c0, sb.size());
        end
    endtask

    task automatic test_flip();
        start = 1'b1; tx_data = 8'h07;
        step();
        sb.push_back('{8'h03, PAR});
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        flip = 1'b1;
        step();
        flip = 1'b0;
        step();
`ifdef SHIFT_PARITY_EN
        checks++;
        if (si !== 1'b1) begin
            errors++;
            $display("FAIL parity_si_bit got %b expected 1", si);
        end
`endif
        wait_ready("flip");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flip_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_small();
        int n = 1;
        start2 = 1'b1; tx2 = 2'b10;
        step();
        sb2.push_back('{8'h02, 1'b0});
        start2 = 1'b0; tx2 = 2'b01;
        while (rx_valid2 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != N2 + 1 + 1) begin
            errors++;
            $display("FAIL small_latency got %0d expected %0d", n, N2 + 2);
        end
        step();
        checks++;
        if (ready2 !== 1'b1 || rx_data2 !== 2'b10 || sb2.size() != 0) begin
            errors++;
            $display("FAIL small_done got rdy=%b d=%b expected 1 10", ready2, rx_data2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_flip();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
